// File: rtl/spell_mem_banked.sv
// Banked data/code DFF memory for the spell core: select/data_ready handshake,
// programmable latency, post-reset clear sweep and code-space write protection.
module spell_mem_banked #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int LATENCY        = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  select,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            memory_type,
    input  logic                  write,
    input  logic                  code_wp,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_ready,
    output logic                  error,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [1:0]            r_type;
    logic                  r_write;
    logic                  r_wp;

    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_ready;
    logic                  r_err;

    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_code_mem [DEPTH];

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_clear_wr;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_din;
    logic [1:0]            w_type;
    logic                  w_write;
    logic                  w_wp;
    logic                  w_invalid;
    logic                  w_we_data;
    logic                  w_we_code;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // A LATENCY=1 request completes on its accepting edge, so it must see live inputs
    assign w_addr  = (r_state == S_IDLE) ? addr        : r_addr;
    assign w_din   = (r_state == S_IDLE) ? data_in     : r_din;
    assign w_type  = (r_state == S_IDLE) ? memory_type : r_type;
    assign w_write = (r_state == S_IDLE) ? write       : r_write;
    assign w_wp    = (r_state == S_IDLE) ? code_wp     : r_wp;

    assign w_invalid = w_type[1]
                     | ((w_type == 2'b01) & w_write & w_wp);

    assign w_we_data = w_complete & ~w_invalid & w_write
                     & (w_type == 2'b00);
    assign w_we_code = w_complete & ~w_invalid & w_write
                     & (w_type == 2'b01);

    assign w_rd_data = w_type[0] ? r_code_mem[w_addr]
                                 : r_data_mem[w_addr];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ptr_next   = r_ptr;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_clear_wr   = 1'b0;
        unique case (r_state)
            S_CLEAR: begin
                w_clear_wr = 1'b1;
                w_ptr_next = r_ptr + 1'b1;
                if (r_ptr == '1) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (select) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_complete   = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_cnt_next   = 4'(LATENCY - 1);
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!select) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_complete   = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                if (!select) begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_cnt   <= 4'd0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            r_addr  <= addr;
            r_din   <= data_in;
            r_type  <= memory_type;
            r_write <= write;
            r_wp    <= code_wp;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dout  <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_complete) begin
            r_ready <= 1'b1;
            r_err   <= w_invalid;
            if (!w_invalid && !w_write) begin
                r_dout <= w_rd_data;
            end
        end else if (r_state == S_DONE && !select) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    // Arrays carry no reset; zeroing is only done by the sweep
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_clear_wr) begin
                r_data_mem[r_ptr] <= '0;
                r_code_mem[r_ptr] <= '0;
            end else if (w_we_data) begin
                r_data_mem[w_addr] <= w_din;
            end else if (w_we_code) begin
                r_code_mem[w_addr] <= w_din;
            end
        end
    end

    assign data_out   = r_dout;
    assign data_ready = r_ready;
    assign error      = r_err;
    assign busy       = (r_state == S_CLEAR);

endmodule

// File: tb/tb_spell_mem_banked.sv
// Randomised bench for spell_mem_banked against an array-based reference model.
module tb_spell_mem_banked;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int LAT   = 4;
    localparam int DEPTH = 256;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          select = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_in = '0;
    logic [1:0]    memory_type = 2'b00;
    logic          write = 1'b0;
    logic          code_wp = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_ready;
    logic          error;
    logic          busy;

    logic [DW-1:0] mdata [DEPTH];
    logic [DW-1:0] mcode [DEPTH];
    logic [DW-1:0] mout;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    spell_mem_banked #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .LATENCY       (LAT),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .select     (select),
        .addr       (addr),
        .data_in    (data_in),
        .memory_type(memory_type),
        .write      (write),
        .code_wp    (code_wp),
        .data_out   (data_out),
        .data_ready (data_ready),
        .error      (error),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on the negedge where reset is released
    task automatic sweep_check();
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge clock);
        end
        chk("busy_len", cnt, DEPTH);
        chk("busy_off", busy, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            mdata[i] = '0;
            mcode[i] = '0;
        end
    endtask

    task automatic req(input logic [1:0] t, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic w,
                       input logic wp, input int hold);
        logic          inv;
        logic [DW-1:0] exp_out;
        int            n;
        inv     = t[1] | (t == 2'b01 && w && wp);
        exp_out = mout;
        if (!inv) begin
            if (w) begin
                if (t[0]) mcode[a] = d;
                else      mdata[a] = d;
            end else begin
                exp_out = t[0] ? mcode[a] : mdata[a];
            end
        end
        mout        = exp_out;
        memory_type = t;
        addr        = a;
        data_in     = d;
        write       = w;
        code_wp     = wp;
        select      = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                addr        = AW'($urandom);
                data_in     = DW'($urandom);
                write       = 1'($urandom);
                memory_type = 2'($urandom);
                code_wp     = 1'($urandom);
            end
        end while (data_ready !== 1'b1 && n < 40);
        chk("latency", n, LAT + 1);
        chk("error", error, inv);
        chk("data_out", data_out, exp_out);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_ready", data_ready, 1'b1);
            chk("hold_out", data_out, exp_out);
        end
        select = 1'b0;
        @(negedge clock);
        chk("drop_ready", data_ready, 1'b0);
        chk("drop_error", error, 1'b0);
    endtask

    initial begin
        mout  = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_ready", data_ready, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_out", data_out, '0);
        chk("rst_busy", busy, 1'b1);
        reset = 1'b0;
        sweep_check();

        req(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 0);
        req(2'b01, 8'hFF, 8'h00, 1'b0, 1'b0, 0);

        req(2'b00, 8'h10, 8'hA5, 1'b1, 1'b0, 0);
        req(2'b00, 8'h10, 8'h00, 1'b0, 1'b0, 0);
        req(2'b01, 8'h10, 8'h00, 1'b0, 1'b0, 0);

        req(2'b01, 8'h20, 8'h3C, 1'b1, 1'b1, 0);
        req(2'b01, 8'h20, 8'h00, 1'b0, 1'b1, 0);
        req(2'b01, 8'h20, 8'h3C, 1'b1, 1'b0, 0);
        req(2'b01, 8'h20, 8'h00, 1'b0, 1'b1, 0);

        req(2'b00, 8'h10, 8'h00, 1'b0, 1'b0, 0);
        req(2'b10, 8'h10, 8'h00, 1'b0, 1'b0, 0);

        req(2'b00, 8'h11, 8'h5A, 1'b1, 1'b0, 5);
        req(2'b00, 8'h11, 8'h00, 1'b0, 1'b0, 5);

        memory_type = 2'b00;
        addr        = 8'h30;
        data_in     = 8'hFF;
        write       = 1'b1;
        code_wp     = 1'b0;
        select      = 1'b1;
        repeat (2) @(negedge clock);
        select = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("abort_ready", data_ready, 1'b0);
        end
        req(2'b00, 8'h30, 8'h00, 1'b0, 1'b0, 0);

        repeat (150) begin
            req(2'($urandom_range(0, 3)), AW'($urandom), DW'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 2));
        end

        reset = 1'b1;
        mout  = '0;
        @(negedge clock);
        reset = 1'b0;
        repeat (100) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_busy", busy, 1'b1);
        reset = 1'b0;
        sweep_check();
        req(2'b00, 8'h10, 8'h00, 1'b0, 1'b0, 0);
        req(2'b01, 8'h20, 8'h00, 1'b0, 1'b0, 0);
        req(2'b00, 8'h11, 8'h00, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
